// File: rtl/row_conv_pkg.sv
// row_conv_pkg: shared bank/drain state types and length helper for the row stream converter
package row_conv_pkg;

    typedef enum logic [1:0] {EMPTY, FILL, FULL, DRAIN} bank_state_t;
    typedef enum logic {IDLE, STREAM} drain_state_t;

    function automatic int eff_len(input int len, input int num_elems);
        return (len == 0) ? num_elems : len;
    endfunction

endpackage

// File: rtl/row_stream_converter_bank.sv
// row_bank: one tile of row storage with latched length and a combinational (optionally skewed) column read
module row_bank
    import row_conv_pkg::*;
#(
    parameter int BUS_WIDTH_BYTES = 32,
    parameter int DATA_WIDTH_BYTES = 1,
    parameter int ARRAY_HEIGHT = 4,
    parameter int SKEW_EN = 0,
    localparam int ELEM_W = DATA_WIDTH_BYTES * 8,
    localparam int NUM_ELEMS = BUS_WIDTH_BYTES / DATA_WIDTH_BYTES,
    localparam int LEN_W = $clog2(NUM_ELEMS),
    localparam int TW = $clog2(NUM_ELEMS + ARRAY_HEIGHT),
    localparam int FW = ARRAY_HEIGHT > 1 ? $clog2(ARRAY_HEIGHT) : 1
) (
    input  logic                           clk,
    input  logic                           we_i,
    input  logic [FW-1:0]                  row_i,
    input  logic [BUS_WIDTH_BYTES*8-1:0]   data_i,
    input  logic                           len_we_i,
    input  logic [LEN_W-1:0]               len_i,
    input  logic [TW-1:0]                  t_i,
    output logic [ARRAY_HEIGHT*ELEM_W-1:0] data_o,
    output logic [ARRAY_HEIGHT-1:0]        lane_valid_o,
    output logic [TW-1:0]                  tmax_o
);
    logic [NUM_ELEMS-1:0][ELEM_W-1:0] mem_q [ARRAY_HEIGHT];
    logic [LEN_W-1:0]                 len_q;
    int                               len_l;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[row_i] <= data_i;
        if (len_we_i) len_q <= len_i;
    end

    assign len_l  = eff_len(int'(len_q), NUM_ELEMS);
    assign tmax_o = TW'(len_l - 1 + (SKEW_EN != 0 ? ARRAY_HEIGHT - 1 : 0));

    // Lane j sees element t-j under skew, so the diagonal wavefront enters the array directly.
    for (genvar j = 0; j < ARRAY_HEIGHT; j++) begin : g_lane
        int k;
        assign k = int'(t_i) - (SKEW_EN != 0 ? j : 0);
        assign lane_valid_o[j] = k >= 0 && k < len_l;
        assign data_o[j*ELEM_W +: ELEM_W] = lane_valid_o[j] ? mem_q[j][LEN_W'(k)] : '0;
    end

endmodule

// File: rtl/row_stream_converter.sv
// row_stream_converter: ping-pong row buffer streaming tiles column by column with ready/valid on both sides
module row_stream_converter
    import row_conv_pkg::*;
#(
    parameter int BUS_WIDTH_BYTES = 32,
    parameter int DATA_WIDTH_BYTES = 1,
    parameter int ARRAY_HEIGHT = 4,
    parameter int SKEW_EN = 0,
    localparam int ELEM_W = DATA_WIDTH_BYTES * 8,
    localparam int NUM_ELEMS = BUS_WIDTH_BYTES / DATA_WIDTH_BYTES,
    localparam int LEN_W = $clog2(NUM_ELEMS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [BUS_WIDTH_BYTES*8-1:0]   data_i,
    input  logic [LEN_W-1:0]               len_i,
    output logic [ARRAY_HEIGHT*ELEM_W-1:0] data_o,
    output logic [ARRAY_HEIGHT-1:0]        lane_valid_o,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic                           last_o
);
    localparam int TW = $clog2(NUM_ELEMS + ARRAY_HEIGHT);
    localparam int FW = ARRAY_HEIGHT > 1 ? $clog2(ARRAY_HEIGHT) : 1;

    if (BUS_WIDTH_BYTES % DATA_WIDTH_BYTES != 0 || ARRAY_HEIGHT < 1) begin : g_param_check
        $error("row_stream_converter: invalid BUS_WIDTH_BYTES/DATA_WIDTH_BYTES/ARRAY_HEIGHT");
    end

    bank_state_t                   st_q [2];
    bank_state_t                   st_d [2];
    drain_state_t                  ds_q, ds_d;
    logic                          fp_q, fp_d, dp_q, dp_d;
    logic [FW-1:0]                 fc_q, fc_d;
    logic [TW-1:0]                 t_q, t_d;
    logic                          rdy_q, rdy_d;
    logic [ARRAY_HEIGHT*ELEM_W-1:0] data_q, data_d;
    logic [ARRAY_HEIGHT-1:0]       lv_q, lv_d;
    logic                          valid_q, valid_d, last_q, last_d;
    logic [ARRAY_HEIGHT*ELEM_W-1:0] bdata [2];
    logic [ARRAY_HEIGHT-1:0]       blv [2];
    logic [TW-1:0]                 btmax [2];
    logic                          wr, acc, last_row, load, sel;

    assign wr       = in_valid_i & rdy_q;
    assign acc      = valid_q & ready_i;
    assign last_row = fc_q == FW'(ARRAY_HEIGHT - 1);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        row_bank #(
            .BUS_WIDTH_BYTES (BUS_WIDTH_BYTES),
            .DATA_WIDTH_BYTES(DATA_WIDTH_BYTES),
            .ARRAY_HEIGHT    (ARRAY_HEIGHT),
            .SKEW_EN         (SKEW_EN)
        ) u_bank (
            .clk         (clk),
            .we_i        (wr && fp_q == 1'(b)),
            .row_i       (fc_q),
            .data_i      (data_i),
            .len_we_i    (wr && fp_q == 1'(b) && fc_q == '0),
            .len_i       (len_i),
            .t_i         (t_d),
            .data_o      (bdata[b]),
            .lane_valid_o(blv[b]),
            .tmax_o      (btmax[b])
        );
    end

    always_comb begin
        st_d    = st_q;
        ds_d    = ds_q;
        fp_d    = fp_q;
        dp_d    = dp_q;
        fc_d    = fc_q;
        t_d     = t_q;
        data_d  = data_q;
        lv_d    = lv_q;
        valid_d = valid_q;
        last_d  = last_q;
        load    = 1'b0;
        sel     = dp_q;
        if (wr) begin
            fc_d       = last_row ? '0 : fc_q + 1'b1;
            st_d[fp_q] = last_row ? FULL : FILL;
            fp_d       = last_row ? ~fp_q : fp_q;
        end
        if (ds_q == IDLE) begin
            if (st_q[dp_q] == FULL) begin
                ds_d       = STREAM;
                st_d[dp_q] = DRAIN;
                t_d        = '0;
                load       = 1'b1;
            end
        end else if (acc) begin
            if (last_q) begin
                st_d[dp_q] = EMPTY;
                dp_d       = ~dp_q;
                t_d        = '0;
                // Chain straight into the other bank when it is ready so tiles stream without a bubble.
                if (st_q[~dp_q] == FULL) begin
                    st_d[~dp_q] = DRAIN;
                    load        = 1'b1;
                    sel         = ~dp_q;
                end else begin
                    ds_d    = IDLE;
                    data_d  = '0;
                    lv_d    = '0;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end
            end else begin
                t_d  = t_q + 1'b1;
                load = 1'b1;
            end
        end
        if (load) begin
            data_d  = bdata[sel];
            lv_d    = blv[sel];
            valid_d = 1'b1;
            last_d  = t_d == btmax[sel];
        end
        rdy_d = st_d[fp_d] inside {EMPTY, FILL};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q    <= '{EMPTY, EMPTY};
            ds_q    <= IDLE;
            fp_q    <= 1'b0;
            dp_q    <= 1'b0;
            fc_q    <= '0;
            t_q     <= '0;
            rdy_q   <= 1'b0;
            data_q  <= '0;
            lv_q    <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            ds_q    <= ds_d;
            fp_q    <= fp_d;
            dp_q    <= dp_d;
            fc_q    <= fc_d;
            t_q     <= t_d;
            rdy_q   <= rdy_d;
            data_q  <= data_d;
            lv_q    <= lv_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign in_ready_o   = rdy_q;
    assign data_o       = data_q;
    assign lane_valid_o = lv_q;
    assign valid_o      = valid_q;
    assign last_o       = last_q;

endmodule

// File: tb/tb_row_stream_converter.sv
// tb_row_stream_converter: random and directed tiles on an aligned and a skewed instance against a tile-level model
module tb_row_stream_converter;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  lv;
        logic        last;
    } beat_t;

    typedef struct packed {
        int    idx;
        beat_t b;
    } pin_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid [2];
    logic [255:0] din [2];
    logic [4:0]   len [2];
    logic         ready [2];
    logic         in_ready [2];
    logic [31:0]  dout [2];
    logic [3:0]   lv [2];
    logic         valid [2];
    logic         last [2];

    int           checks = 0;
    int           errors = 0;
    beat_t        exq [2][$];
    pin_t         pins [2][$];
    logic [255:0] rows [2][4];
    logic [4:0]   tlen [2];
    int           nrow [2];
    int           held [2];
    int           vcnt [2];
    int           nbeat [2];
    logic         prev_rst [2] = '{1'b1, 1'b1};
    int           rmode [2] = '{0, 0};
    int           rc = 0;

    always #5 clk = ~clk;

    row_stream_converter #(.SKEW_EN(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
        .data_i(din[0]), .len_i(len[0]), .data_o(dout[0]), .lane_valid_o(lv[0]),
        .valid_o(valid[0]), .ready_i(ready[0]), .last_o(last[0])
    );

    row_stream_converter #(.SKEW_EN(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
        .data_i(din[1]), .len_i(len[1]), .data_o(dout[1]), .lane_valid_o(lv[1]),
        .valid_o(valid[1]), .ready_i(ready[1]), .last_o(last[1])
    );

    task automatic chk(input string name, input int s, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h, expected %h at %0t", name, s, act, exp, $time);
        end
    endtask

    // Model: a tile's expected beats follow from its four rows, its length and the lane skew.
    always @(negedge clk) begin
        int h0, l_eff, t_tot, k;
        beat_t cur, nb;
        for (int s = 0; s < 2; s++) begin
            if (reset) begin
                exq[s].delete();
                nrow[s] = 0;
                held[s] = 0;
                vcnt[s] = 0;
            end else begin
                h0 = held[s];
                cur = {dout[s], lv[s], last[s]};
                chk("in_ready", s, 64'(in_ready[s]), 64'(!prev_rst[s] && h0 < 2));
                if (vcnt[s] == 1) chk("valid_timing", s, 64'(valid[s]), 64'd1);
                if (vcnt[s] > 0) vcnt[s]--;
                if (valid[s]) begin
                    if (exq[s].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat dut%0d: got %h, expected no beat", s, cur);
                    end else begin
                        chk("beat", s, 64'(cur), 64'(exq[s][0]));
                        if (pins[s].size() != 0 && pins[s][0].idx == nbeat[s]) begin
                            chk("pinned_beat", s, 64'(cur), 64'(pins[s][0].b));
                            if (ready[s]) void'(pins[s].pop_front());
                        end
                        if (ready[s]) begin
                            if (exq[s][0].last) begin
                                if (h0 == 2) vcnt[s] = 1;
                                held[s]--;
                            end
                            void'(exq[s].pop_front());
                            nbeat[s]++;
                        end
                    end
                end else begin
                    chk("idle_outputs_zero", s, 64'(cur), 64'd0);
                end
                if (in_valid[s] && in_ready[s]) begin
                    rows[s][nrow[s]] = din[s];
                    if (nrow[s] == 0) tlen[s] = len[s];
                    nrow[s]++;
                    if (nrow[s] == 4) begin
                        l_eff = tlen[s] == 0 ? 32 : int'(tlen[s]);
                        t_tot = l_eff + (s == 1 ? 3 : 0);
                        for (int t = 0; t < t_tot; t++) begin
                            nb = '0;
                            for (int j = 0; j < 4; j++) begin
                                k = t - (s == 1 ? j : 0);
                                if (k >= 0 && k < l_eff) begin
                                    nb.lv[j] = 1'b1;
                                    nb.d[j*8 +: 8] = rows[s][j][k*8 +: 8];
                                end
                            end
                            nb.last = t == t_tot - 1;
                            exq[s].push_back(nb);
                        end
                        if (h0 == 0) vcnt[s] = 2;
                        held[s]++;
                        nrow[s] = 0;
                    end
                end
            end
            prev_rst[s] = reset;
        end
    end

    initial begin
        ready = '{1'b1, 1'b1};
        forever begin
            @(posedge clk);
            #1;
            rc++;
            for (int s = 0; s < 2; s++)
                ready[s] = rmode[s] == 1 ? ($urandom_range(0, 2) != 0) :
                           rmode[s] == 2 ? !(rc % 4 == 1 || rc % 4 == 2) : 1'b1;
        end
    end

    function automatic logic [255:0] dir_row(input int r);
        logic [255:0] w;
        for (int k = 0; k < 32; k++) w[k*8 +: 8] = 8'(16 * r + k);
        return w;
    endfunction

    function automatic logic [255:0] rand_row();
        logic [255:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic send_word(input int u, input logic [255:0] w, input logic [4:0] l);
        int n = 0;
        in_valid[u] = 1'b1;
        din[u] = w;
        len[u] = l;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready[u] && n < 1000);
        if (!in_ready[u]) begin
            $display("FAIL in_ready_timeout dut%0d: got 0, expected 1 within 1000 cycles", u);
            $fatal(1, "input stalled");
        end
        @(posedge clk);
        #1;
        in_valid[u] = 1'b0;
    endtask

    task automatic send_tile(input int u, input logic [4:0] l, input bit dir, input int max_gap);
        for (int r = 0; r < 4; r++) begin
            send_word(u, dir ? dir_row(r) : rand_row(), l);
            repeat ($urandom_range(0, max_gap)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic pin(input int u, input int off, input logic [31:0] d, input logic [3:0] l, input logic la);
        pin_t p;
        p.idx = nbeat[u] + off;
        p.b.d = d;
        p.b.lv = l;
        p.b.last = la;
        pins[u].push_back(p);
    endtask

    task automatic dir_pins(input int u, input bit full_len);
        if (full_len) begin
            if (u == 0) pin(u, 31, 32'h4F3F2F1F, 4'hF, 1'b1);
            else pin(u, 34, 32'h4F000000, 4'b1000, 1'b1);
        end else if (u == 0) begin
            for (int b = 0; b < 4; b++)
                pin(u, b, {8'h30 + 8'(b), 8'h20 + 8'(b), 8'h10 + 8'(b), 8'(b)}, 4'hF, b == 3);
        end else begin
            pin(u, 0, 32'h00000000, 4'b0001, 1'b0);
            pin(u, 3, 32'h30211203, 4'hF, 1'b0);
            pin(u, 6, 32'h33000000, 4'b1000, 1'b1);
        end
    endtask

    task automatic wait_idle(input int u);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exq[u].size() != 0 || pins[u].size() != 0 || valid[u] || nrow[u] != 0) && n < 5000);
        if (n >= 5000) begin
            $display("FAIL drain_timeout dut%0d: got %0d beats outstanding, expected 0", u, exq[u].size());
            $fatal(1, "drain stalled");
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        in_valid = '{1'b0, 1'b0};
        din = '{'0, '0};
        len = '{'0, '0};
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int u = 0; u < 2; u++) begin
            dir_pins(u, 1'b0);
            send_tile(u, 5'd4, 1'b1, 0);
            wait_idle(u);
            dir_pins(u, 1'b1);
            send_tile(u, 5'd0, 1'b1, 0);
            wait_idle(u);
            for (int i = 0; i < 3; i++) send_tile(u, 5'($urandom_range(1, 6)), 1'b0, 0);
            wait_idle(u);
            rmode[u] = 2;
            for (int i = 0; i < 2; i++) send_tile(u, 5'($urandom_range(0, 31)), 1'b0, 0);
            wait_idle(u);
            rmode[u] = 0;
            send_word(u, dir_row(0), 5'd4);
            send_word(u, dir_row(1), 5'd4);
            reset = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            reset = 1'b0;
            dir_pins(u, 1'b0);
            send_tile(u, 5'd4, 1'b1, 0);
            wait_idle(u);
            rmode[u] = 1;
            for (int i = 0; i < 6; i++) send_tile(u, 5'($urandom_range(0, 31)), 1'b0, 2);
            wait_idle(u);
            rmode[u] = 0;
        end
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
